// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants, EX control bundle and load classifier
package mips_pkg;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // The five registered control bits; a bubble is simply all-zero.
   typedef struct packed {
      logic valid;
      logic regwr;
      logic alusrc;
      logic memwr;
      logic memtoreg;
   } ex_ctrl_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } lu_state_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID->EX bundle: decoded ID fields in, registered EX fields and stall controls out
interface id_ex_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          id_valid;
   logic [5:0]    id_op;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic          id_rt_used;
   logic          id_regwr, id_regdst, id_alusrc, id_memwr, id_memtoreg;
   logic [DW-1:0] id_busA, id_busB, id_imm32, id_pc;
   logic          br_flush;
   logic          mem_busy;

   logic          ex_valid, ex_regwr, ex_alusrc, ex_memwr, ex_memtoreg;
   logic [5:0]    ex_op;
   logic [RW-1:0] ex_rs, ex_rt, ex_dst;
   logic [DW-1:0] ex_busA, ex_busB, ex_imm32, ex_pc;
   logic          ifid_hold;
   logic          lu_stall;

   modport master (
      output id_valid, id_op, id_rs, id_rt, id_rd, id_rt_used,
             id_regwr, id_regdst, id_alusrc, id_memwr, id_memtoreg,
             id_busA, id_busB, id_imm32, id_pc, br_flush, mem_busy,
      input  ex_valid, ex_regwr, ex_alusrc, ex_memwr, ex_memtoreg, ex_op,
             ex_rs, ex_rt, ex_dst, ex_busA, ex_busB, ex_imm32, ex_pc,
             ifid_hold, lu_stall
   );

   modport slave (
      input  id_valid, id_op, id_rs, id_rt, id_rd, id_rt_used,
             id_regwr, id_regdst, id_alusrc, id_memwr, id_memtoreg,
             id_busA, id_busB, id_imm32, id_pc, br_flush, mem_busy,
      output ex_valid, ex_regwr, ex_alusrc, ex_memwr, ex_memtoreg, ex_op,
             ex_rs, ex_rt, ex_dst, ex_busA, ex_busB, ex_imm32, ex_pc,
             ifid_hold, lu_stall
   );
endinterface

// File: rtl/lu_detect.sv
// rtl/lu_detect.sv - combinational load-use compare between the load in EX and the sources read in ID
module lu_detect
   import mips_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic          ex_valid,
   input  logic          ex_regwr,
   input  logic          ex_memtoreg,
   input  logic [5:0]    ex_op,
   input  logic [RW-1:0] ex_dst,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_rt_used,
   output logic          hz
);
   logic src_match;

   assign src_match = (ex_dst == id_rs) || (id_rt_used && (ex_dst == id_rt));

   // $0 is hardwired, so a load targeting it can never feed a consumer.
   assign hz = ex_valid && ex_regwr && ex_memtoreg && is_load(ex_op) &&
               (ex_dst != '0) && id_valid && src_match;
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with load-use stall FSM, flush and memory-wait hold
// Optional HAZARD_STATS_EN adds stall_cnt/flush_cnt ports.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   id_ex_if.slave      bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);
   lu_state_t     state;
   logic          lu_stall_q;
   ex_ctrl_t      ex_ctrl, id_ctrl;
   logic [5:0]    ex_op_q;
   logic [RW-1:0] ex_rs_q, ex_rt_q, ex_dst_q;
   logic [DW-1:0] ex_busA_q, ex_busB_q, ex_imm32_q, ex_pc_q;
   logic          hz;
   logic          take_stall;

   lu_detect #(.RW(RW)) u_lu_detect (
      .ex_valid    (ex_ctrl.valid),
      .ex_regwr    (ex_ctrl.regwr),
      .ex_memtoreg (ex_ctrl.memtoreg),
      .ex_op       (ex_op_q),
      .ex_dst      (ex_dst_q),
      .id_valid    (bus.id_valid),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_rt_used  (bus.id_rt_used),
      .hz          (hz)
   );

   // An invalid ID slot enters EX as a bubble so stray controls never commit.
   assign id_ctrl.valid    = bus.id_valid;
   assign id_ctrl.regwr    = bus.id_valid & bus.id_regwr;
   assign id_ctrl.alusrc   = bus.id_valid & bus.id_alusrc;
   assign id_ctrl.memwr    = bus.id_valid & bus.id_memwr;
   assign id_ctrl.memtoreg = bus.id_valid & bus.id_memtoreg;

   assign take_stall = (state == ST_RUN) && hz && !bus.br_flush && !bus.mem_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         lu_stall_q <= 1'b0;
         ex_ctrl    <= '0;
         ex_op_q    <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_dst_q   <= '0;
         ex_busA_q  <= '0;
         ex_busB_q  <= '0;
         ex_imm32_q <= '0;
         ex_pc_q    <= '0;
      end else if (bus.br_flush) begin
         ex_ctrl    <= '0;
         state      <= ST_RUN;
         lu_stall_q <= 1'b0;
      end else if (!bus.mem_busy) begin
         if (take_stall) begin
            ex_ctrl    <= '0;
            state      <= ST_BUBBLE;
            lu_stall_q <= 1'b1;
         end else begin
            // BUBBLE always falls through here: the load has moved on to MEM.
            ex_ctrl    <= id_ctrl;
            ex_op_q    <= bus.id_op;
            ex_rs_q    <= bus.id_rs;
            ex_rt_q    <= bus.id_rt;
            ex_dst_q   <= bus.id_regdst ? bus.id_rd : bus.id_rt;
            ex_busA_q  <= bus.id_busA;
            ex_busB_q  <= bus.id_busB;
            ex_imm32_q <= bus.id_imm32;
            ex_pc_q    <= bus.id_pc;
            state      <= ST_RUN;
            lu_stall_q <= 1'b0;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.br_flush) flush_cnt <= flush_cnt + 32'd1;
         if (take_stall)   stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

   assign bus.ifid_hold   = bus.mem_busy | ((state == ST_RUN) & hz & ~bus.br_flush);
   assign bus.lu_stall    = lu_stall_q;
   assign bus.ex_valid    = ex_ctrl.valid;
   assign bus.ex_regwr    = ex_ctrl.regwr;
   assign bus.ex_alusrc   = ex_ctrl.alusrc;
   assign bus.ex_memwr    = ex_ctrl.memwr;
   assign bus.ex_memtoreg = ex_ctrl.memtoreg;
   assign bus.ex_op       = ex_op_q;
   assign bus.ex_rs       = ex_rs_q;
   assign bus.ex_rt       = ex_rt_q;
   assign bus.ex_dst      = ex_dst_q;
   assign bus.ex_busA     = ex_busA_q;
   assign bus.ex_busB     = ex_busB_q;
   assign bus.ex_imm32    = ex_imm32_q;
   assign bus.ex_pc       = ex_pc_q;
endmodule
